uart_fifo_loopback: RTL and testbench

Parametrised UART echo block. A self-contained receiver, a byte FIFO and a transmitter sit between the board's serial RX pin and TX pin. Every correctly framed byte received is queued and retransmitted in order. It adds configurable baud divisor, buffering depth, TX flow-control pause, framing-error detection and overflow reporting, so back-to-back and bursty traffic echoes without loss.

---
 rtl/uart_fifo_loopback.sv | 294 +++++++++++++++++++++++++++++
 tb/tb_uart_fifo_loopback.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_fifo_loopback.sv
// uart_fifo_loopback: UART echo block. Bytes received on i_uart_rx with a good stop bit
// are queued in a byte FIFO and retransmitted in order on o_uart_tx.
//
// Parameters:
//   CLKS_PER_BIT  clock cycles per UART bit (>= 4)
//   FIFO_DEPTH    FIFO entries (power of two, >= 2)
//
// Ports:
//   i_Clk         main clock
//   i_Rst         synchronous active-high reset
//   i_uart_rx     serial RX line (asynchronous, idle high)
//   i_Pause       holds off new TX frames; a frame in progress completes
//   o_uart_tx     serial TX line (idle high)
//   o_tx_active   high from TX start bit through stop bit
//   o_rx_dv       one-cycle pulse per good received byte (stored or dropped)
//   o_frame_err   one-cycle pulse when the RX stop bit samples low
//   o_overflow    sticky; a good byte was dropped because the FIFO was full
//   o_fifo_count  current FIFO occupancy
//
// Build option: define UART_LOOPBACK_CASE_FLIP_EN to invert bit 5 of ASCII letters as they
// are loaded into the transmitter ('a' <-> 'A'). Undefined: bytes echo unmodified.

module uart_fifo_loopback #(
  parameter int unsigned CLKS_PER_BIT = 217,
  parameter int unsigned FIFO_DEPTH   = 16
) (
  input  logic                          i_Clk,
  input  logic                          i_Rst,
  input  logic                          i_uart_rx,
  input  logic                          i_Pause,
  output logic                          o_uart_tx,
  output logic                          o_tx_active,
  output logic                          o_rx_dv,
  output logic                          o_frame_err,
  output logic                          o_overflow,
  output logic [$clog2(FIFO_DEPTH):0]   o_fifo_count
);

  localparam int unsigned AddrW = $clog2(FIFO_DEPTH);
  localparam int unsigned CntW  = $clog2(CLKS_PER_BIT);

  localparam logic [CntW-1:0]  BitLast   = CntW'(CLKS_PER_BIT - 1);
  // Start bit is re-sampled near its middle to reject glitches and centre later samples.
  localparam logic [CntW-1:0]  HalfLast  = CntW'((CLKS_PER_BIT - 1) / 2);
  localparam logic [AddrW:0]   CountFull = (AddrW + 1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {RxIdle, RxStart, RxData, RxStop} rx_state_e;
  typedef enum logic [1:0] {TxIdle, TxStart, TxData, TxStop} tx_state_e;

  // ---------------------------------------------------------------------------
  // RX synchroniser
  // ---------------------------------------------------------------------------
  logic rx_meta_q, rx_sync_q;

  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
    end else begin
      rx_meta_q <= i_uart_rx;
      rx_sync_q <= rx_meta_q;
    end
  end

  // ---------------------------------------------------------------------------
  // RX FSM
  // ---------------------------------------------------------------------------
  rx_state_e       rx_state_q, rx_state_d;
  logic [CntW-1:0] rx_cnt_q, rx_cnt_d;
  logic [2:0]      rx_bit_q, rx_bit_d;
  logic [7:0]      rx_shift_q, rx_shift_d;
  logic            rx_dv_q, frame_err_q;
  logic            rx_good, rx_bad;

  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      rx_state_q  <= RxIdle;
      rx_cnt_q    <= '0;
      rx_bit_q    <= '0;
      rx_shift_q  <= '0;
      rx_dv_q     <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      rx_state_q  <= rx_state_d;
      rx_cnt_q    <= rx_cnt_d;
      rx_bit_q    <= rx_bit_d;
      rx_shift_q  <= rx_shift_d;
      rx_dv_q     <= rx_good;
      frame_err_q <= rx_bad;
    end
  end

  always_comb begin
    rx_state_d = rx_state_q;
    rx_cnt_d   = rx_cnt_q;
    rx_bit_d   = rx_bit_q;
    rx_shift_d = rx_shift_q;
    unique case (rx_state_q)
      RxIdle: begin
        if (!rx_sync_q) begin
          rx_state_d = RxStart;
          rx_cnt_d   = '0;
        end
      end
      RxStart: begin
        if (rx_cnt_q == HalfLast) begin
          rx_cnt_d   = '0;
          rx_bit_d   = '0;
          rx_state_d = rx_sync_q ? RxIdle : RxData;
        end else begin
          rx_cnt_d = rx_cnt_q + 1'b1;
        end
      end
      RxData: begin
        if (rx_cnt_q == BitLast) begin
          rx_cnt_d   = '0;
          rx_shift_d = {rx_sync_q, rx_shift_q[7:1]};
          if (rx_bit_q == 3'd7) rx_state_d = RxStop;
          else                  rx_bit_d   = rx_bit_q + 1'b1;
        end else begin
          rx_cnt_d = rx_cnt_q + 1'b1;
        end
      end
      RxStop: begin
        if (rx_cnt_q == BitLast) begin
          rx_cnt_d   = '0;
          rx_state_d = RxIdle;
        end else begin
          rx_cnt_d = rx_cnt_q + 1'b1;
        end
      end
      default: rx_state_d = RxIdle;
    endcase
  end

  // Stop-bit verdict; the FIFO push happens on this same edge so the count and
  // the registered o_rx_dv pulse become visible together.
  always_comb begin
    rx_good = 1'b0;
    rx_bad  = 1'b0;
    if (rx_state_q == RxStop && rx_cnt_q == BitLast) begin
      rx_good = rx_sync_q;
      rx_bad  = ~rx_sync_q;
    end
  end

  // ---------------------------------------------------------------------------
  // FIFO
  // ---------------------------------------------------------------------------
  logic [7:0]       mem_q [FIFO_DEPTH];
  logic [AddrW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AddrW:0]   count_q, count_d;
  logic             overflow_q;
  logic             fifo_full, push_ok, tx_pop;
  logic [7:0]       head_byte, load_byte;

  assign fifo_full = (count_q == CountFull);
  // A pop in the same cycle frees the slot, so a push into a full FIFO still succeeds.
  assign push_ok   = rx_good & (~fifo_full | tx_pop);
  assign head_byte = mem_q[rd_ptr_q];

  always_comb begin
    count_d = count_q;
    unique case ({push_ok, tx_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (tx_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_d;
      if (rx_good && !push_ok) overflow_q <= 1'b1;
    end
  end

  always_ff @(posedge i_Clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= rx_shift_q;
  end

`ifdef UART_LOOPBACK_CASE_FLIP_EN
  logic is_letter;
  assign is_letter = ((head_byte >= 8'h41) && (head_byte <= 8'h5A)) ||
                     ((head_byte >= 8'h61) && (head_byte <= 8'h7A));
  assign load_byte = is_letter ? (head_byte ^ 8'h20) : head_byte;
`else
  assign load_byte = head_byte;
`endif

  // ---------------------------------------------------------------------------
  // TX FSM
  // ---------------------------------------------------------------------------
  tx_state_e       tx_state_q, tx_state_d;
  logic [CntW-1:0] tx_cnt_q, tx_cnt_d;
  logic [2:0]      tx_bit_q, tx_bit_d;
  logic [7:0]      tx_shift_q, tx_shift_d;
  logic            can_start;

  assign can_start = (count_q != '0) & ~i_Pause;

  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      tx_state_q <= TxIdle;
      tx_cnt_q   <= '0;
      tx_bit_q   <= '0;
      tx_shift_q <= '0;
    end else begin
      tx_state_q <= tx_state_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_bit_q   <= tx_bit_d;
      tx_shift_q <= tx_shift_d;
    end
  end

  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q;
    tx_bit_d   = tx_bit_q;
    tx_shift_d = tx_shift_q;
    unique case (tx_state_q)
      TxIdle: begin
        if (tx_pop) begin
          tx_state_d = TxStart;
          tx_cnt_d   = '0;
          tx_shift_d = load_byte;
        end
      end
      TxStart: begin
        if (tx_cnt_q == BitLast) begin
          tx_cnt_d   = '0;
          tx_bit_d   = '0;
          tx_state_d = TxData;
        end else begin
          tx_cnt_d = tx_cnt_q + 1'b1;
        end
      end
      TxData: begin
        if (tx_cnt_q == BitLast) begin
          tx_cnt_d   = '0;
          tx_shift_d = {1'b0, tx_shift_q[7:1]};
          if (tx_bit_q == 3'd7) tx_state_d = TxStop;
          else                  tx_bit_d   = tx_bit_q + 1'b1;
        end else begin
          tx_cnt_d = tx_cnt_q + 1'b1;
        end
      end
      TxStop: begin
        if (tx_cnt_q == BitLast) begin
          tx_cnt_d = '0;
          // Chain straight into the next start bit so back-to-back frames have no gap.
          if (tx_pop) begin
            tx_state_d = TxStart;
            tx_shift_d = load_byte;
          end else begin
            tx_state_d = TxIdle;
          end
        end else begin
          tx_cnt_d = tx_cnt_q + 1'b1;
        end
      end
      default: tx_state_d = TxIdle;
    endcase
  end

  always_comb begin
    o_uart_tx   = 1'b1;
    o_tx_active = 1'b1;
    tx_pop      = 1'b0;
    unique case (tx_state_q)
      TxIdle: begin
        o_tx_active = 1'b0;
        tx_pop      = can_start;
      end
      TxStart: o_uart_tx = 1'b0;
      TxData:  o_uart_tx = tx_shift_q[0];
      TxStop:  tx_pop    = can_start & (tx_cnt_q == BitLast);
      default: o_tx_active = 1'b0;
    endcase
  end

  assign o_rx_dv      = rx_dv_q;
  assign o_frame_err  = frame_err_q;
  assign o_overflow   = overflow_q;
  assign o_fifo_count = count_q;

endmodule

// File: tb/tb_uart_fifo_loopback.sv
// Bench for uart_fifo_loopback: dut1 (CLKS_PER_BIT=4, FIFO_DEPTH=4) and dut2 (FIFO_DEPTH=2).
// Expected echo bytes are queued when RX stimulus is driven and popped by TX frame monitors.

module tb_uart_fifo_loopback;

  localparam int unsigned Cpb = 4;
  localparam int FrameCycles  = 10 * Cpb;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       rx1, pause1, tx1, act1, dv1, fe1, ovf1;
  logic [2:0] cnt1;
  logic       rx2, pause2, tx2, act2, dv2, fe2, ovf2;
  logic [1:0] cnt2;

  uart_fifo_loopback #(.CLKS_PER_BIT(Cpb), .FIFO_DEPTH(4)) u_dut1 (
    .i_Clk        (clk),
    .i_Rst        (rst),
    .i_uart_rx    (rx1),
    .i_Pause      (pause1),
    .o_uart_tx    (tx1),
    .o_tx_active  (act1),
    .o_rx_dv      (dv1),
    .o_frame_err  (fe1),
    .o_overflow   (ovf1),
    .o_fifo_count (cnt1)
  );

  uart_fifo_loopback #(.CLKS_PER_BIT(Cpb), .FIFO_DEPTH(2)) u_dut2 (
    .i_Clk        (clk),
    .i_Rst        (rst),
    .i_uart_rx    (rx2),
    .i_Pause      (pause2),
    .o_uart_tx    (tx2),
    .o_tx_active  (act2),
    .o_rx_dv      (dv2),
    .o_frame_err  (fe2),
    .o_overflow   (ovf2),
    .o_fifo_count (cnt2)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  logic [7:0] exp_q1[$];
  logic [7:0] exp_q2[$];
  int         starts1[$];
  int         frames1 = 0, frames2 = 0, last_start1 = 0;
  int         dv_n1 = 0, fe_n1 = 0, act_n1 = 0, last_dv1 = 0, act_n2 = 0;
  bit         mon_en1 = 1'b1;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (dv1 === 1'b1) begin
      dv_n1    <= dv_n1 + 1;
      last_dv1 <= cyc;
    end
    if (fe1 === 1'b1)  fe_n1  <= fe_n1 + 1;
    if (act1 === 1'b1) act_n1 <= act_n1 + 1;
    if (act2 === 1'b1 || dv2 === 1'b1 || fe2 === 1'b1) act_n2 <= act_n2 + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] echo_of(input logic [7:0] b);
`ifdef UART_LOOPBACK_CASE_FLIP_EN
    if ((b >= 8'h41 && b <= 8'h5A) || (b >= 8'h61 && b <= 8'h7A)) return b ^ 8'h20;
`endif
    return b;
  endfunction

  // Called at the negedge where the start bit is first seen; samples all 40 cycles.
  task automatic mon_frame(input int which, output logic [7:0] data, output logic stop_bit,
                           output int unstable);
    logic [9:0] bits;
    logic       v;
    bits     = '0;
    unstable = 0;
    for (int b = 0; b < 10; b++) begin
      for (int c = 0; c < Cpb; c++) begin
        if (!(b == 0 && c == 0)) @(negedge clk);
        v = (which == 1) ? tx1 : tx2;
        if (c == 0) bits[b] = v;
        else if (v !== bits[b]) unstable++;
      end
    end
    if (bits[0] !== 1'b0) unstable++;
    data     = bits[8:1];
    stop_bit = bits[9];
  endtask

  initial begin : mon1
    logic [7:0] d;
    logic       s;
    int         u;
    forever begin
      @(negedge clk);
      if (mon_en1 && rst === 1'b0 && tx1 === 1'b0) begin
        last_start1 = cyc;
        starts1.push_back(cyc);
        frames1++;
        mon_frame(1, d, s, u);
        if (exp_q1.size() == 0) check("tx1_unexpected", {24'd0, d}, 32'h100);
        else                    check("tx1_byte", {24'd0, d}, {24'd0, exp_q1.pop_front()});
        check("tx1_stop", {31'd0, s}, 32'd1);
        check("tx1_bit_width", u, 0);
      end
    end
  end

  initial begin : mon2
    logic [7:0] d;
    logic       s;
    int         u;
    forever begin
      @(negedge clk);
      if (rst === 1'b0 && tx2 === 1'b0) begin
        frames2++;
        mon_frame(2, d, s, u);
        if (exp_q2.size() == 0) check("tx2_unexpected", {24'd0, d}, 32'h100);
        else                    check("tx2_byte", {24'd0, d}, {24'd0, exp_q2.pop_front()});
        check("tx2_stop", {31'd0, s}, 32'd1);
        check("tx2_bit_width", u, 0);
      end
    end
  end

  // Starts and ends just after a posedge; consecutive calls give back-to-back frames.
  task automatic send_byte(input int which, input logic [7:0] b, input logic stop_bit);
    logic [9:0] f;
    f = {stop_bit, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      if (which == 1) rx1 = f[i];
      else            rx2 = f[i];
      repeat (Cpb) @(posedge clk);
      #1;
    end
    if (which == 1) rx1 = 1'b1;
    else            rx2 = 1'b1;
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_drain(input int which, input int budget, input string tag);
    int i;
    i = 0;
    while (((which == 1) ? exp_q1.size() : exp_q2.size()) != 0 && i < budget) begin
      @(negedge clk);
      i++;
    end
    check(tag, (which == 1) ? exp_q1.size() : exp_q2.size(), 0);
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : main
    int dv0, fe0, act0, fr0, p, i;
    logic [7:0] burst[5];
    rst = 1'b1; rx1 = 1'b1; rx2 = 1'b1; pause1 = 1'b0; pause2 = 1'b0;

    // Reset values
    step(3);
    check("rst_tx",    tx1,  1);
    check("rst_act",   act1, 0);
    check("rst_dv",    dv1,  0);
    check("rst_ferr",  fe1,  0);
    check("rst_ovf",   ovf1, 0);
    check("rst_count", cnt1, 0);
    check("rst_tx2",   tx2,  1);
    check("rst_count2", cnt2, 0);
    rst = 1'b0;
    step(2);

    // Single echo, TX start one cycle after o_rx_dv
    dv0 = dv_n1;
    exp_q1.push_back(echo_of(8'h5A));
    send_byte(1, 8'h5A, 1'b1);
    wait_drain(1, 200, "t2_drain");
    check("t2_dv_pulses", dv_n1 - dv0, 1);
    check("t2_latency", last_start1 - last_dv1, 1);
    step(5);

    // Burst while paused: four stored, fifth dropped
    pause1 = 1'b1;
    dv0 = dv_n1; fr0 = frames1;
    for (int k = 0; k < 5; k++) burst[k] = 8'(k + 1);
    for (int k = 0; k < 4; k++) exp_q1.push_back(echo_of(burst[k]));
    for (int k = 0; k < 5; k++) send_byte(1, burst[k], 1'b1);
    step(4);
    check("t3_count", cnt1, 4);
    check("t3_ovf", ovf1, 1);
    check("t3_dv_pulses", dv_n1 - dv0, 5);
    check("t3_no_tx_paused", frames1 - fr0, 0);
    starts1.delete();
    p = cyc;
    pause1 = 1'b0;
    wait_drain(1, 400, "t3_drain");
    check("t3_frames", starts1.size(), 4);
    if (starts1.size() == 4) begin
      check("t3_first_start", starts1[0] - p, 1);
      for (int k = 1; k < 4; k++) check("t3_contiguous", starts1[k] - starts1[k-1], FrameCycles);
    end
    step(60);
    check("t3_no_fifth", frames1 - fr0, 4);

    // Framing error
    dv0 = dv_n1; fe0 = fe_n1; act0 = act_n1; fr0 = frames1;
    send_byte(1, 8'h33, 1'b0);
    step(10);
    check("t4_ferr_pulses", fe_n1 - fe0, 1);
    check("t4_no_dv", dv_n1 - dv0, 0);
    check("t4_count", cnt1, 0);
    check("t4_no_tx", act_n1 - act0, 0);
    check("t4_ovf_sticky", ovf1, 1);

    // One-cycle glitch on RX
    dv0 = dv_n1; fe0 = fe_n1; act0 = act_n1;
    rx1 = 1'b0;
    step(1);
    rx1 = 1'b1;
    step(20);
    check("t5_glitch_dv", dv_n1 - dv0, 0);
    check("t5_glitch_ferr", fe_n1 - fe0, 0);
    check("t5_glitch_tx", act_n1 - act0, 0);

    // Reset in the middle of a TX frame with one byte still queued
    mon_en1 = 1'b0;
    pause1 = 1'b1;
    send_byte(1, 8'h11, 1'b1);
    send_byte(1, 8'h22, 1'b1);
    step(2);
    pause1 = 1'b0;
    i = 0;
    while (act1 !== 1'b1 && i < 20) begin
      step(1);
      i++;
    end
    check("t5_tx_started", act1, 1);
    step(15);
    check("t5_count_before", cnt1, 1);
    rst = 1'b1;
    step(1);
    check("t5_rst_tx", tx1, 1);
    check("t5_rst_act", act1, 0);
    check("t5_rst_count", cnt1, 0);
    check("t5_rst_ovf", ovf1, 0);
    rst = 1'b0;
    act0 = act_n1;
    step(60);
    check("t5_fifo_empty", act_n1 - act0, 0);
    mon_en1 = 1'b1;

    // Depth-2 FIFO: pushes into a full FIFO coincide with TX pops
    pause2 = 1'b1;
    exp_q2.push_back(echo_of(8'h61));
    exp_q2.push_back(echo_of(8'h42));
    exp_q2.push_back(echo_of(8'h7A));
    exp_q2.push_back(echo_of(8'h30));
    exp_q2.push_back(echo_of(8'hC5));
    send_byte(2, 8'h61, 1'b1);
    send_byte(2, 8'h42, 1'b1);
    fr0 = frames2;
    fork
      begin
        send_byte(2, 8'h7A, 1'b1);
        send_byte(2, 8'h30, 1'b1);
        send_byte(2, 8'hC5, 1'b1);
      end
      begin
        // Release on the cycle the third byte's stop bit is sampled.
        repeat (FrameCycles) @(posedge clk);
        #1;
        pause2 = 1'b0;
        step(1);
        check("t6_count_full", cnt2, 2);
        check("t6_ovf_clear", ovf2, 0);
      end
    join
    wait_drain(2, 400, "t6_drain");
    check("t6_frames", frames2 - fr0, 5);
    check("t6_ovf_end", ovf2, 0);
    check("t6_count_end", cnt2, 0);
    check("t6_activity", (act_n2 > 0) ? 1 : 0, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
